// File: rtl/chain_stim_ctrl.sv
// Stimulus/measurement controller for a gated NOR delay chain: flushes the chain,
// drives a programmable pulse train, then counts synchronized output rises and first-pulse latency.
module chain_stim_ctrl #(
  parameter int unsigned FLUSH_CYC = 4,
  parameter int unsigned TMO_W     = 12
) (
  input  logic             myclk,
  input  logic             myrst_n,
  input  logic             start,
  input  logic [7:0]       pulse_width,
  input  logic [7:0]       gap_width,
  input  logic [7:0]       num_pulses,
  input  logic [TMO_W-1:0] timeout,
  input  logic             chain_out,
  output logic             chain_in,
  output logic             chain_gnd,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic [7:0]       out_pulses,
  output logic [TMO_W-1:0] first_lat
);

  localparam int unsigned CNT_W = (TMO_W + 1 > 16) ? TMO_W + 1 : 16;

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_SETTLE, S_HIGH, S_LOW, S_DRAIN, S_DONE
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [7:0]         pw_q, gw_q, np_q, rem;
  logic [TMO_W-1:0]   tmo_q, lat_cnt;
  logic               lat_started, lat_run;
  logic               sync1, sync2, prev;
  logic [1:0]         zcnt;

  logic [7:0]         pw_eff_c, gw_eff_c;
  logic [CNT_W-1:0]   seg_len_c;
  logic               seg_end_c, rise_c, count_en_c, rise_cnt_c, quiet_c, expire_c;

  // Segment length for the current timed state; zero widths behave as one cycle.
  always_comb begin
    pw_eff_c   = (pw_q == 8'd0) ? 8'd1 : pw_q;
    gw_eff_c   = (gw_q == 8'd0) ? 8'd1 : gw_q;
    seg_len_c  = '0;
    case (state)
      S_FLUSH:        seg_len_c = CNT_W'(FLUSH_CYC);
      S_SETTLE, S_LOW: seg_len_c = CNT_W'(gw_eff_c);
      S_HIGH:         seg_len_c = CNT_W'(pw_eff_c);
      default:        seg_len_c = '0;
    endcase
    seg_end_c  = (cnt + CNT_W'(1)) >= seg_len_c;
    rise_c     = sync2 & ~prev;
    count_en_c = (state == S_SETTLE) || (state == S_HIGH) ||
                 (state == S_LOW)    || (state == S_DRAIN);
    rise_cnt_c = rise_c & count_en_c;
    quiet_c    = (state == S_DRAIN) && !sync2 && (zcnt == 2'd3);
    expire_c   = (state == S_DRAIN) && ((cnt + CNT_W'(1)) >= CNT_W'(tmo_q));
  end

  always_ff @(posedge myclk or negedge myrst_n) begin
    if (!myrst_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (start) state_d = S_FLUSH;
      S_FLUSH:  if (seg_end_c) state_d = S_SETTLE;
      S_SETTLE: if (seg_end_c) state_d = (np_q != 8'd0) ? S_HIGH : S_DRAIN;
      S_HIGH:   if (seg_end_c) state_d = S_LOW;
      S_LOW:    if (seg_end_c) state_d = (rem > 8'd1) ? S_HIGH : S_DRAIN;
      S_DRAIN:  if (quiet_c || expire_c) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge myclk or negedge myrst_n) begin
    if (!myrst_n) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      prev        <= 1'b0;
      cnt         <= '0;
      pw_q        <= '0;
      gw_q        <= '0;
      np_q        <= '0;
      rem         <= '0;
      tmo_q       <= '0;
      lat_cnt     <= '0;
      lat_started <= 1'b0;
      lat_run     <= 1'b0;
      zcnt        <= '0;
      out_pulses  <= '0;
      first_lat   <= '1;
      err_timeout <= 1'b0;
      chain_in    <= 1'b0;
      chain_gnd   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      sync1 <= chain_out;
      sync2 <= sync1;
      prev  <= sync2;
      cnt   <= (state_d != state) ? '0 : cnt + CNT_W'(1);

      if (state == S_IDLE && start) begin
        pw_q        <= pulse_width;
        gw_q        <= gap_width;
        np_q        <= num_pulses;
        rem         <= num_pulses;
        tmo_q       <= timeout;
        out_pulses  <= '0;
        first_lat   <= '1;
        err_timeout <= 1'b0;
        lat_started <= 1'b0;
        lat_run     <= 1'b0;
      end

      if (state == S_LOW && state_d != S_LOW) rem <= rem - 8'd1;

      // Run of consecutive quiet synchronized samples while draining
      if (state != S_DRAIN || sync2) zcnt <= '0;
      else if (zcnt != 2'd3)         zcnt <= zcnt + 2'd1;

      if (rise_cnt_c && out_pulses != 8'hFF) out_pulses <= out_pulses + 8'd1;

      // Latency runs from the first HIGH entry until the first counted rise
      if (state_d == S_HIGH && state != S_HIGH && !lat_started) begin
        lat_started <= 1'b1;
        lat_run     <= 1'b1;
        lat_cnt     <= '0;
      end else if (lat_run) begin
        if (rise_cnt_c) begin
          lat_run   <= 1'b0;
          first_lat <= lat_cnt;
        end else if (lat_cnt != '1) begin
          lat_cnt <= lat_cnt + TMO_W'(1);
        end
      end

      if (expire_c && !quiet_c) err_timeout <= 1'b1;

      chain_in  <= (state_d == S_HIGH);
      chain_gnd <= (state_d == S_IDLE) || (state_d == S_FLUSH) || (state_d == S_DONE);
      busy      <= (state_d != S_IDLE);
      done      <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_chain_stim_ctrl.sv
// Directed bench for chain_stim_ctrl with a 6-cycle, short-pulse-filtering chain model.
module tb_chain_stim_ctrl;

  localparam int unsigned TMO_W      = 12;
  localparam int          RUN_BUDGET = 2000;

  logic             myclk, myrst_n, start;
  logic [7:0]       pulse_width, gap_width, num_pulses;
  logic [TMO_W-1:0] timeout;
  logic             chain_out, chain_in, chain_gnd, busy, done, err_timeout;
  logic [7:0]       out_pulses;
  logic [TMO_W-1:0] first_lat;

  logic [5:0] sr;
  logic       stuck;

  int errors = 0;
  int checks = 0;

  chain_stim_ctrl #(.FLUSH_CYC(4), .TMO_W(TMO_W)) dut (
    .myclk(myclk), .myrst_n(myrst_n), .start(start),
    .pulse_width(pulse_width), .gap_width(gap_width), .num_pulses(num_pulses),
    .timeout(timeout), .chain_out(chain_out), .chain_in(chain_in),
    .chain_gnd(chain_gnd), .busy(busy), .done(done), .err_timeout(err_timeout),
    .out_pulses(out_pulses), .first_lat(first_lat)
  );

  initial myclk = 1'b0;
  always #5 myclk = ~myclk;

  // Chain model: 6-cycle delay, output high only after 3 consecutive high inputs
  always @(posedge myclk) sr <= chain_gnd ? 6'd0 : {sr[4:0], chain_in};
  assign chain_out = (stuck & ~chain_gnd) | (sr[5] & sr[4] & sr[3]);

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_seq(input logic [7:0] pw, input logic [7:0] gw, input logic [7:0] np,
                         input logic [TMO_W-1:0] tmo, input bit poke,
                         output int t_done, output int hi_cyc, output int last_fall,
                         output int done_cnt);
    bit prev_in, poked;
    @(negedge myclk);
    pulse_width = pw; gap_width = gw; num_pulses = np; timeout = tmo; start = 1'b1;
    t_done = -1; hi_cyc = 0; last_fall = -1; done_cnt = 0; prev_in = 1'b0; poked = 1'b0;
    for (int i = 1; i <= RUN_BUDGET; i++) begin
      @(negedge myclk);
      start = 1'b0;
      if (chain_in) hi_cyc++;
      if (prev_in && !chain_in) begin
        last_fall = i;
        if (poke && !poked) begin
          start = 1'b1; num_pulses = 8'd1; poked = 1'b1;
        end
      end
      prev_in = chain_in;
      if (done) begin
        done_cnt++;
        if (t_done < 0) t_done = i;
      end
      if (t_done >= 0 && i >= t_done + 3) break;
    end
    check("done_seen", int'(t_done >= 0), 1);
  endtask

  int t_done, hi_cyc, last_fall, done_cnt, rises, seen_done;
  bit prev_ci;

  initial begin
    myrst_n = 1'b0; start = 1'b0; stuck = 1'b0; sr = '0;
    pulse_width = '0; gap_width = '0; num_pulses = '0; timeout = '0;
    repeat (2) @(negedge myclk);
    check("rst_chain_gnd", int'(chain_gnd), 1);
    check("rst_chain_in", int'(chain_in), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err_timeout), 0);
    check("rst_pulses", int'(out_pulses), 0);
    check("rst_lat", int'(first_lat), 4095);
    myrst_n = 1'b1;
    repeat (3) @(negedge myclk);

    // Nominal 3-pulse run
    run_seq(8'd10, 8'd10, 8'd3, 12'd100, 1'b0, t_done, hi_cyc, last_fall, done_cnt);
    check("nom_pulses", int'(out_pulses), 3);
    check("nom_lat", int'(first_lat), 8);
    check("nom_err", int'(err_timeout), 0);
    check("nom_hi_cyc", hi_cyc, 30);
    check("nom_done_cnt", done_cnt, 1);
    check("nom_busy_end", int'(busy), 0);
    check("nom_gnd_end", int'(chain_gnd), 1);

    // Short pulses swallowed by the chain
    run_seq(8'd2, 8'd3, 8'd5, 12'd100, 1'b0, t_done, hi_cyc, last_fall, done_cnt);
    check("short_pulses", int'(out_pulses), 0);
    check("short_lat", int'(first_lat), 4095);
    check("short_hi_cyc", hi_cyc, 10);
    check("short_done_cnt", done_cnt, 1);

    // Stuck-high chain: drain times out
    stuck = 1'b1;
    run_seq(8'd4, 8'd4, 8'd1, 12'd20, 1'b0, t_done, hi_cyc, last_fall, done_cnt);
    check("stuck_err", int'(err_timeout), 1);
    check("stuck_drain_len", t_done - last_fall, 24);
    check("stuck_pulses", int'(out_pulses), 1);
    check("stuck_done_cnt", done_cnt, 1);

    run_seq(8'd4, 8'd4, 8'd1, 12'd0, 1'b0, t_done, hi_cyc, last_fall, done_cnt);
    check("tmo0_err", int'(err_timeout), 1);
    check("tmo0_drain_len", t_done - last_fall, 5);
    stuck = 1'b0;
    repeat (3) @(negedge myclk);

    // No pulses, zero widths: FLUSH 4 + SETTLE 1 + DRAIN 4 then DONE
    run_seq(8'd0, 8'd0, 8'd0, 12'd100, 1'b0, t_done, hi_cyc, last_fall, done_cnt);
    check("np0_t_done", t_done, 10);
    check("np0_hi_cyc", hi_cyc, 0);
    check("np0_pulses", int'(out_pulses), 0);
    check("np0_err_cleared", int'(err_timeout), 0);
    check("np0_lat", int'(first_lat), 4095);

    // Start during LOW is ignored
    run_seq(8'd10, 8'd10, 8'd3, 12'd100, 1'b1, t_done, hi_cyc, last_fall, done_cnt);
    check("poke_pulses", int'(out_pulses), 3);
    check("poke_lat", int'(first_lat), 8);
    check("poke_hi_cyc", hi_cyc, 30);
    check("poke_done_cnt", done_cnt, 1);

    // Reset during the second pulse aborts the run
    @(negedge myclk);
    pulse_width = 8'd10; gap_width = 8'd10; num_pulses = 8'd3; timeout = 12'd100; start = 1'b1;
    @(negedge myclk);
    start = 1'b0; rises = 0; prev_ci = 1'b0;
    for (int i = 0; i < RUN_BUDGET; i++) begin
      @(negedge myclk);
      if (chain_in && !prev_ci) rises++;
      prev_ci = chain_in;
      if (rises == 2) break;
    end
    check("abort_reach", rises, 2);
    repeat (3) @(negedge myclk);
    check("abort_pre_pulses", int'(out_pulses), 1);
    myrst_n = 1'b0;
    #1;
    check("abort_chain_in", int'(chain_in), 0);
    check("abort_chain_gnd", int'(chain_gnd), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_pulses", int'(out_pulses), 0);
    check("abort_lat", int'(first_lat), 4095);
    seen_done = 0;
    repeat (3) begin
      @(negedge myclk);
      if (done) seen_done++;
    end
    myrst_n = 1'b1;
    repeat (6) begin
      @(negedge myclk);
      if (done) seen_done++;
    end
    check("abort_no_done", seen_done, 0);

    run_seq(8'd10, 8'd10, 8'd3, 12'd100, 1'b0, t_done, hi_cyc, last_fall, done_cnt);
    check("rerun_pulses", int'(out_pulses), 3);
    check("rerun_lat", int'(first_lat), 8);
    check("rerun_hi_cyc", hi_cyc, 30);
    check("rerun_err", int'(err_timeout), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
